// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer, occupancy and flag controller for a single-clock
// FIFO built around an external memory with a registered write port and a
// combinational read port. Optional almost-full/almost-empty watermark flags
// are compiled in when the macro SYNC_FIFO_WATERMARK_EN is defined.

`ifndef FIFO_DEPTH
`define FIFO_DEPTH 16
`endif

module sync_fifo_ctrl #(
    parameter int FIFO_DEPTH = `FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic                  rd_req,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH + 1)'(1);
    // With a power-of-two depth, FIFO_DEPTH is exactly the wrap bit of a pointer.
    localparam logic [ADDR_WIDTH:0] WRAP_BIT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_inc;
    logic [ADDR_WIDTH:0]   rd_ptr_inc;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  push_ok;
    logic                  pop_ok;

    assign full        = (state == ST_FULL);
    assign empty       = (state == ST_EMPTY);
    // The reset term keeps the memory from being written while reset is held.
    assign push_ok     = wr_req & ~full & ~reset;
    assign pop_ok      = rd_req & ~empty;
    assign mem_wr_en   = push_ok;
    assign mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign wr_ptr_inc  = wr_ptr + ONE;
    assign rd_ptr_inc  = rd_ptr + ONE;

    // Next occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
    always_comb begin
        // NOTE: default first, so every path assigns and no latch is inferred.
        count_next = fifo_count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = fifo_count + ONE;
            2'b01:   count_next = fifo_count - ONE;
            default: count_next = fifo_count;
        endcase
    end

    // Next state: full when the advanced tail lands one lap ahead of the head,
    // empty when the advanced head catches up with the tail.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (push_ok) state_next = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (push_ok && !pop_ok && (wr_ptr_inc == (rd_ptr ^ WRAP_BIT)))
                    state_next = ST_FULL;
                else if (pop_ok && !push_ok && (rd_ptr_inc == wr_ptr))
                    state_next = ST_EMPTY;
            end
            ST_FULL: begin
                if (pop_ok) state_next = ST_PARTIAL;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // State register, pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: only control state is reset; the memory contents are left as-is.
        if (reset) begin
            state      <= ST_EMPTY;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state      <= state_next;
            fifo_count <= count_next;
            if (push_ok) wr_ptr <= wr_ptr_inc;
            if (pop_ok)  rd_ptr <= rd_ptr_inc;
            if (wr_req && full)  overflow  <= 1'b1;
            if (rd_req && empty) underflow <= 1'b1;
        end
    end

`ifdef SYNC_FIFO_WATERMARK_EN
    localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C = (ADDR_WIDTH + 1)'(AE_LEVEL);

    // Watermark flags registered from the next occupancy, in step with fifo_count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: scoreboard bench for sync_fifo_ctrl. A behavioural queue
// model decides which requests are accepted; popped data is queued as the
// expected response and checked by a separate monitor when the DUT accepts
// a pop. Define SYNC_FIFO_WATERMARK_EN to also check the watermark flags.

module tb_sync_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req;
    logic          rd_req;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [AW-1:0] mem_rd_addr;
    logic          full;
    logic          empty;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic          underflow;
`ifdef SYNC_FIFO_WATERMARK_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    sync_fifo_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_WIDTH (AW)
`ifdef SYNC_FIFO_WATERMARK_EN
        ,
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_rd_addr (mem_rd_addr),
        .full        (full),
        .empty       (empty),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef SYNC_FIFO_WATERMARK_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    // FIFO storage the controller addresses: registered write, combinational read.
    logic [7:0] mem [DEPTH];
    logic [7:0] wdata;
    always @(posedge clk) if (mem_wr_en) mem[mem_wr_addr] <= wdata;

    // Reference model and scoreboard.
    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    int         n_push;
    int         n_pop;
    bit         m_ovf;
    bit         m_unf;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_q.delete();
        n_push = 0;
        n_pop  = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic check_state();
        check("count",    32'(fifo_count),  32'(q.size()));
        check("full",     32'(full),        32'(q.size() == DEPTH));
        check("empty",    32'(empty),       32'(q.size() == 0));
        check("overflow", 32'(overflow),    32'(m_ovf));
        check("underflow",32'(underflow),   32'(m_unf));
        check("wr_addr",  32'(mem_wr_addr), 32'(n_push % DEPTH));
        check("rd_addr",  32'(mem_rd_addr), 32'(n_pop % DEPTH));
`ifdef SYNC_FIFO_WATERMARK_EN
        check("almost_full",  32'(almost_full),  32'(q.size() >= AF));
        check("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
`endif
    endtask

    // One clock of stimulus: check the settled state, drive requests, and let
    // the model decide acceptance from the occupancy before the edge.
    task automatic step(input bit wr, input bit rd);
        bit push_ok;
        bit pop_ok;
        @(negedge clk);
        check_state();
        wr_req  = wr;
        rd_req  = rd;
        wdata   = 8'($urandom);
        push_ok = wr && (q.size() < DEPTH);
        pop_ok  = rd && (q.size() > 0);
        #1;
        check("mem_wr_en", 32'(mem_wr_en), 32'(push_ok));
        if (pop_ok) begin
            exp_q.push_back(q.pop_front());
            n_pop++;
        end
        if (push_ok) begin
            q.push_back(wdata);
            n_push++;
        end
        if (wr && !push_ok) m_ovf = 1'b1;
        if (rd && !pop_ok)  m_unf = 1'b1;
    endtask

    // Monitor: whenever the DUT accepts a pop, the head data must match.
    always @(negedge clk) begin
        #2;
        if (!reset && rd_req && !empty) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_data: DUT popped %0h with no entry expected at %0t",
                         mem[mem_rd_addr], $time);
            end else begin
                check("pop_data", 32'(mem[mem_rd_addr]), 32'(exp_q.pop_front()));
            end
        end
    end

    int bias_w[3] = '{80, 30, 50};
    int bias_r[3] = '{30, 80, 50};

    initial begin
        model_reset();
        reset  = 1'b1;
        wr_req = 1'b1;
        rd_req = 1'b0;
        wdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state();
        check("wr_en_in_reset", 32'(mem_wr_en), 32'(0));
        wr_req = 1'b0;
        reset  = 1'b0;

        // Fill to full, then push+pop while full.
        repeat (DEPTH) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        while (q.size() > 0) step(1'b0, 1'b1);

        // Push+pop while empty: push accepted, pop rejected.
        step(1'b1, 1'b1);
        while (q.size() < 8) step(1'b1, 1'b0);

        // Steady flow at occupancy 8; both addresses wrap.
        repeat (20) step(1'b1, 1'b1);
        while (q.size() > 0) step(1'b0, 1'b1);

        // Randomised phases: fill-biased, drain-biased, balanced.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(99) < bias_w[p], $urandom_range(99) < bias_r[p]);
            end
        end

        // Asynchronous reset mid-cycle with five entries held.
        while (q.size() > 0) step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("count_before_reset", 32'(fifo_count), 32'(5));
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_state();
        check("wr_en_in_reset", 32'(mem_wr_en), 32'(0));
        @(posedge clk);
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        reset  = 1'b0;

        // Operation resumes from a clean state.
        repeat (3) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        @(negedge clk);
        #3;
        check_state();
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default `FIFO_DEPTH (16): number of memory entries; SHALL be a power of two, at least 2.
REQ-002 Parameter ADDR_WIDTH, default $clog2(FIFO_DEPTH): memory address width.
REQ-003 Parameter AF_LEVEL, default FIFO_DEPTH-2: almost-full threshold; present only when SYNC_FIFO_WATERMARK_EN is defined.
REQ-004 Parameter AE_LEVEL, default 2: almost-empty threshold; present only when SYNC_FIFO_WATERMARK_EN is defined.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 wr_req  input  1  push request for the current cycle.
REQ-008 rd_req  input  1  pop request for the current cycle.
REQ-009 mem_wr_en  output  1  write strobe to the FIFO memory; combinational.
REQ-010 mem_wr_addr  output  ADDR_WIDTH  write address (tail pointer, low bits).
REQ-011 mem_rd_addr  output  ADDR_WIDTH  read address (head pointer, low bits); memory read data is combinational from this address.
REQ-012 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-013 empty  output  1  FIFO holds 0 entries.
REQ-014 fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
REQ-015 overflow  output  1  sticky flag: a push was rejected.
REQ-016 underflow  output  1  sticky flag: a pop was rejected.
REQ-017 almost_full, almost_empty  output  1 each  watermark flags; present only when SYNC_FIFO_WATERMARK_EN is defined.

Function
REQ-018 Write and read pointers SHALL each be ADDR_WIDTH+1 bits: low bits form the address, MSB is the wrap bit.
REQ-019 A push is accepted when wr_req=1 and full=0; mem_wr_en SHALL equal (wr_req & ~full).
REQ-020 A pop is accepted when rd_req=1 and empty=0; head data is valid on the memory read port in the same cycle as the request.
REQ-021 An accepted push SHALL increment the write pointer at the next edge; an accepted pop SHALL increment the read pointer at the next edge.
REQ-022 Pointers SHALL wrap modulo 2*FIFO_DEPTH, so the address wraps from FIFO_DEPTH-1 to 0 and the wrap bit toggles.
REQ-023 The state register SHALL hold one of EMPTY, PARTIAL or FULL, with full=(state==FULL) and empty=(state==EMPTY), both registered.
REQ-024 State transitions SHALL be:
- EMPTY->PARTIAL on an accepted push (or EMPTY->FULL on that push when FIFO_DEPTH=1 is excluded, i.e. never).
- PARTIAL->FULL when a push is accepted without a pop and count reaches FIFO_DEPTH.
- PARTIAL->EMPTY when a pop is accepted without a push and count reaches 0.
- FULL->PARTIAL on an accepted pop.
- Otherwise the state holds.
REQ-025 fifo_count SHALL be registered and change by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-026 When full, wr_req SHALL be rejected even if a pop is accepted in the same cycle.
REQ-027 When empty, rd_req SHALL be rejected even if a push is accepted in the same cycle; there is no fall-through.
REQ-028 In PARTIAL, a simultaneous push and pop SHALL both be accepted, with count and state unchanged.
REQ-029 overflow SHALL set one cycle after a rejected push and hold until reset.
REQ-030 underflow SHALL set one cycle after a rejected pop and hold until reset.

Reset
REQ-031 reset=1 SHALL asynchronously force pointers to 0, state to EMPTY, fifo_count to 0, empty=1, full=0, overflow=0, underflow=0, almost_empty=1 and almost_full=0.
REQ-032 Reset asserted mid-operation SHALL discard all occupancy; memory contents are not cleared.
REQ-033 mem_wr_en SHALL be 0 while reset=1.

Configuration
REQ-034 The watermark feature is controlled by the macro SYNC_FIFO_WATERMARK_EN.
REQ-035 When defined, almost_full SHALL register (next count >= AF_LEVEL) and almost_empty SHALL register (next count <= AE_LEVEL), both updating on the same edge as fifo_count.
REQ-036 When undefined, the almost_full and almost_empty ports, the AF_LEVEL and AE_LEVEL parameters, and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Reset, then 16 consecutive pushes at FIFO_DEPTH=16 -> mem_wr_addr runs 0..15, full=1 after the 16th edge, fifo_count=16, overflow=0.
REQ-038 From full, wr_req=1 and rd_req=1 together -> pop accepted, mem_wr_en=0, fifo_count=15, overflow=1 on the next cycle.
REQ-039 From empty, rd_req=1 and wr_req=1 together -> push accepted, pop rejected, fifo_count=1, underflow=1, empty=0.
REQ-040 Push 20 entries and pop 20 entries interleaved with count held at 8 -> both addresses wrap 15->0, the data order is preserved, and count stays 8 during simultaneous operations.
REQ-041 Assert reset asynchronously mid-cycle with fifo_count=5 -> all outputs take their reset values immediately, before the next clock edge.
REQ-042 With SYNC_FIFO_WATERMARK_EN, AF_LEVEL=14, AE_LEVEL=2, fill from 0 to 16 -> almost_empty=1 at counts 0..2, almost_full=1 at counts 14..16.
